// File: rtl/segre_pkg.sv
// Shared types and constants for the segre memory responder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package segre_pkg;

    localparam int ADDR_SIZE        = 32;
    localparam int DCACHE_LINE_SIZE = 128;
    localparam int MEM_LATENCY_DEF  = 5;

    // Latency counter wide enough for MEM_LATENCY up to 15 (loads at most 13).
    localparam int LAT_CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/segre_mem_array.sv
// Line storage: single synchronous read/write port, contents survive reset.
// Latency: read data appears one clock after the enabled read cycle.
// Backpressure: none; the owner serialises every access.
module segre_mem_array #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 128
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // One port: a write commits the line, a read refreshes the output register.
    // The output register only moves on reads, so it holds the last read line.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                r_mem[idx_i] <= wdata_i;
            end else begin
                r_rdata <= r_mem[idx_i];
            end
        end
    end

    assign rdata_o = r_rdata;

endmodule

// File: rtl/segre_mem_responder.sv
// Fixed-latency main memory model serving one cache line request at a time.
// Latency: ready pulse MEM_LATENCY cycles after the request is captured.
// Backpressure: requests are ignored while busy; caches hold them until served.
module segre_mem_responder
    import segre_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int MEM_DEPTH   = 1024
) (
    input  logic                        clk_i,
    input  logic                        rsn_i,
    input  logic                        mem_rd_i,
    input  logic                        mem_wr_i,
    input  logic                        sel_mem_req_i,
    input  logic [ADDR_SIZE-1:0]        mem_addr_i,
    input  logic [DCACHE_LINE_SIZE-1:0] mem_data_i,
    output logic [DCACHE_LINE_SIZE-1:0] mem_data_o,
    output logic                        mem_ready_ic_o,
    output logic                        mem_ready_dc_o,
    output logic                        mem_busy_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    // One cycle is spent capturing and one in RESP; BUSY covers the rest.
    localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(MEM_LATENCY - 2);

    mem_state_e                   r_state;
    logic [LAT_CNT_W-1:0]         r_cnt;
    logic [IDX_W-1:0]             r_idx;
    logic [DCACHE_LINE_SIZE-1:0]  r_wdata;
    logic                         r_is_wr;
    logic                         r_sel;
    logic                         r_rd_done;

    logic                         w_req;
    logic                         w_arr_en;
    logic [DCACHE_LINE_SIZE-1:0]  w_rdata;
    logic                         w_unused;

    assign w_req    = mem_rd_i | mem_wr_i;
    // The array is touched exactly once, on the BUSY->RESP edge; reset on that
    // edge aborts the access so an interrupted write never lands.
    assign w_arr_en = (r_state == BUSY) && (r_cnt == '0) && !rsn_i;

    // Offset bits and address bits above the index wrap away.
    assign w_unused = ^{mem_addr_i[3:0], mem_addr_i[ADDR_SIZE-1:4+IDX_W]};

    // Control FSM: capture, count down the latency, one-cycle response.
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rd_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state <= BUSY;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                        if (!r_is_wr) begin
                            r_rd_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Request fields are latched on acceptance; write wins when both are set.
    always_ff @(posedge clk_i) begin
        if (r_state == IDLE && w_req) begin
            r_idx   <= mem_addr_i[4 +: IDX_W];
            r_wdata <= mem_data_i;
            r_is_wr <= mem_wr_i;
            r_sel   <= sel_mem_req_i;
        end
    end

    segre_mem_array #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DCACHE_LINE_SIZE)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (w_arr_en),
        .we_i    (r_is_wr),
        .idx_i   (r_idx),
        .wdata_i (r_wdata),
        .rdata_o (w_rdata)
    );

    // The array output register has no reset, so the port reads zero until
    // the first read after reset has completed; afterwards it holds.
    assign mem_data_o     = r_rd_done ? w_rdata : '0;
    assign mem_ready_ic_o = (r_state == RESP) && !r_sel;
    assign mem_ready_dc_o = (r_state == RESP) &&  r_sel;
    assign mem_busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_segre_mem_responder.sv
// Bench for segre_mem_responder: directed scenarios plus random traffic.
// Latency: expected ready cycle derived from the acceptance cycle.
// Backpressure: driver holds each request until its modelled completion.
module tb_segre_mem_responder;
    import segre_pkg::*;

    localparam int LAT   = 5;
    localparam int DEPTH = 1024;

    logic         clk_i = 1'b0;
    logic         rsn_i;
    logic         mem_rd_i;
    logic         mem_wr_i;
    logic         sel_mem_req_i;
    logic [31:0]  mem_addr_i;
    logic [127:0] mem_data_i;
    logic [127:0] mem_data_o;
    logic         mem_ready_ic_o;
    logic         mem_ready_dc_o;
    logic         mem_busy_o;

    segre_mem_responder #(
        .MEM_LATENCY (LAT),
        .MEM_DEPTH   (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rsn_i          (rsn_i),
        .mem_rd_i       (mem_rd_i),
        .mem_wr_i       (mem_wr_i),
        .sel_mem_req_i  (sel_mem_req_i),
        .mem_addr_i     (mem_addr_i),
        .mem_data_i     (mem_data_i),
        .mem_data_o     (mem_data_o),
        .mem_ready_ic_o (mem_ready_ic_o),
        .mem_ready_dc_o (mem_ready_dc_o),
        .mem_busy_o     (mem_busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Cycle n is the interval after the n-th rising edge.
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic         sel;
        logic [127:0] data;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] model_mem [int];
    logic [127:0] model_dout = '0;
    int           next_free  = 0;
    int           checks     = 0;
    int           failures   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive a request and hold it until the model says it is served.
    task automatic issue(input logic rd, input logic wr, input logic sel,
                         input logic [31:0] addr, input logic [127:0] data);
        int   acc;
        int   idx;
        exp_t e;
        mem_rd_i      = rd;
        mem_wr_i      = wr;
        sel_mem_req_i = sel;
        mem_addr_i    = addr;
        mem_data_i    = data;
        acc = (cyc > next_free) ? cyc : next_free;
        idx = int'((addr >> 4) % DEPTH);
        if (wr) model_mem[idx] = data;
        else    model_dout = model_mem.exists(idx) ? model_mem[idx] : '0;
        e.cyc  = acc + LAT;
        e.sel  = sel;
        e.data = model_dout;
        sb.push_back(e);
        next_free = acc + LAT + 1;
        while (cyc < acc + LAT) @(negedge clk_i);
        mem_rd_i = 1'b0;
        mem_wr_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: every ready pulse is matched against the scoreboard head.
    initial begin
        logic prev_rdy;
        exp_t e;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk_i);
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_ready at cycle %0d: no pulse, required in cycle %0d", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (mem_ready_ic_o || mem_ready_dc_o) begin
                chk("ready_both", {127'd0, mem_ready_ic_o & mem_ready_dc_o}, 128'd0);
                chk("ready_consecutive", {127'd0, prev_rdy}, 128'd0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready at cycle %0d: ic=%0b dc=%0b, none required",
                             cyc, mem_ready_ic_o, mem_ready_dc_o);
                end else if (sb[0].cyc != cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL ready_timing: pulse in cycle %0d, required in cycle %0d", cyc, sb[0].cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ready_dc_sel", {127'd0, mem_ready_dc_o}, {127'd0, e.sel});
                    chk("ready_ic_sel", {127'd0, mem_ready_ic_o}, {127'd0, !e.sel});
                    chk("resp_data", mem_data_o, e.data);
                end
            end
            prev_rdy = mem_ready_ic_o | mem_ready_dc_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] old_val;
        logic [127:0] pool_data;
        int           pool [8];
        int           c0;
        int           op;
        int           idx;
        logic [31:0]  addr;

        rsn_i = 1'b1;
        mem_rd_i = 1'b0;
        mem_wr_i = 1'b0;
        sel_mem_req_i = 1'b0;
        mem_addr_i = '0;
        mem_data_i = '0;
        idle(3);
        chk("reset_busy", {127'd0, mem_busy_o}, 128'd0);
        chk("reset_ready_ic", {127'd0, mem_ready_ic_o}, 128'd0);
        chk("reset_ready_dc", {127'd0, mem_ready_dc_o}, 128'd0);
        chk("reset_data", mem_data_o, 128'd0);
        rsn_i = 1'b0;
        next_free = cyc;

        // Write via data cache, read back via instruction cache.
        issue(1'b0, 1'b1, 1'b1, 32'h100, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
        issue(1'b1, 1'b0, 1'b0, 32'h100, '0);
        // Offset bits ignored.
        idle(2);
        issue(1'b1, 1'b0, 1'b1, 32'h10F, '0);
        // Index wraps modulo depth.
        issue(1'b0, 1'b1, 1'b0, 32'h4100, 128'h11112222_33334444_55556666_77778888);
        issue(1'b1, 1'b0, 1'b1, 32'h0100, '0);
        // rd and wr together behave as a write; data port unchanged in its RESP.
        idle(1);
        issue(1'b1, 1'b1, 1'b1, 32'h200, {16{8'h5A}});
        issue(1'b1, 1'b0, 1'b0, 32'h200, '0);

        // Reset in cycle 3 of a write aborts it.
        old_val = rnd128();
        issue(1'b0, 1'b1, 1'b1, 32'h300, old_val);
        idle(2);
        c0 = cyc;
        mem_wr_i = 1'b1;
        sel_mem_req_i = 1'b0;
        mem_addr_i = 32'h300;
        mem_data_i = ~old_val;
        while (cyc < c0 + 3) @(negedge clk_i);
        rsn_i = 1'b1;
        mem_wr_i = 1'b0;
        @(negedge clk_i);
        chk("abort_busy", {127'd0, mem_busy_o}, 128'd0);
        chk("abort_data", mem_data_o, 128'd0);
        rsn_i = 1'b0;
        model_dout = '0;
        next_free = cyc;
        issue(1'b1, 1'b0, 1'b1, 32'h300, '0);

        // Continuous read request: back-to-back service, 6-cycle period.
        idle(2);
        issue(1'b1, 1'b0, 1'b0, 32'h100, '0);
        issue(1'b1, 1'b0, 1'b1, 32'h200, '0);
        issue(1'b1, 1'b0, 1'b0, 32'h300, '0);

        // Random traffic over a small line pool with random offset/upper bits.
        for (int i = 0; i < 8; i++) begin
            pool[i] = 16 + int'($urandom_range(0, DEPTH - 17));
            pool_data = rnd128();
            issue(1'b0, 1'b1, 1'($urandom_range(0, 1)), 32'(pool[i] << 4), pool_data);
        end
        for (int i = 0; i < 60; i++) begin
            op   = int'($urandom_range(0, 2));
            idx  = pool[$urandom_range(0, 7)];
            addr = ($urandom & 32'hFFFF_C000) | 32'(idx << 4) | ($urandom & 32'hF);
            idle(int'($urandom_range(0, 2)));
            issue(op != 1, op != 0, 1'($urandom_range(0, 1)), addr, rnd128());
        end

        idle(LAT + 4);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
